// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: one bit per cycle, valid/ready on both sides.
// Optional rotate support is enabled by defining SEQ_SHIFTER_ROTATE_EN (adds port rot).
module seq_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [SHW-1:0]   shamt,
   input  logic             dir,
   input  logic             arith,
`ifdef SEQ_SHIFTER_ROTATE_EN
   input  logic             rot,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] z,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [SHW-1:0]   cnt_q;
   logic             dir_q;
   logic             arith_q;
`ifdef SEQ_SHIFTER_ROTATE_EN
   logic             rot_q;
`endif

   logic             fill_c;
   logic [WIDTH-1:0] step_c;

   // Single-bit shift of the data register; during an arithmetic right shift
   // the MSB always still holds the latched sign bit, so it is reused as fill.
   always_comb begin
      fill_c = 1'b0;
      step_c = data_q;
      if (dir_q) begin
`ifdef SEQ_SHIFTER_ROTATE_EN
         fill_c = rot_q ? data_q[WIDTH-1] : 1'b0;
`else
         fill_c = 1'b0;
`endif
         step_c = {data_q[WIDTH-2:0], fill_c};
      end else begin
`ifdef SEQ_SHIFTER_ROTATE_EN
         fill_c = rot_q ? data_q[0] : (arith_q & data_q[WIDTH-1]);
`else
         fill_c = arith_q & data_q[WIDTH-1];
`endif
         step_c = {fill_c, data_q[WIDTH-1:1]};
      end
   end

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         z         <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         arith_q   <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
         rot_q     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= x;
                  cnt_q    <= shamt;
                  dir_q    <= dir;
                  arith_q  <= arith;
`ifdef SEQ_SHIFTER_ROTATE_EN
                  rot_q    <= rot;
`endif
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (shamt == '0) begin
                     state     <= DONE;
                     z         <= x;
                     out_valid <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               data_q <= step_c;
               cnt_q  <= cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  state     <= DONE;
                  z         <= step_c;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (WIDTH=32).
// Rotate scenarios are included when SEQ_SHIFTER_ROTATE_EN is defined.
module tb_seq_shifter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic [4:0]  shamt;
   logic        dir;
   logic        arith;
   logic        rot;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] z;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   seq_shifter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .shamt     (shamt),
      .dir       (dir),
      .arith     (arith),
`ifdef SEQ_SHIFTER_ROTATE_EN
      .rot       (rot),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request when idle; report result and edges-to-valid latency.
   task automatic req(input logic [31:0] xv, input int sh, input logic d, input logic a,
                      input logic r, output logic [31:0] zz, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      x = xv; shamt = 5'(sh); dir = d; arith = a; rot = r; in_valid = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      zz = z;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #2;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (z !== 32'h0) begin failures++; $display("FAIL reset_z got=%h exp=00000000", z); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_arith_right();
      logic [31:0] zz; int lat;
      req(32'h8000_0000, 4, 1'b0, 1'b1, 1'b0, zz, lat);
      checks++; if (zz !== 32'hF800_0000) begin failures++; $display("FAIL sra4_z got=%h exp=f8000000", zz); end
      checks++; if (lat !== 5) begin failures++; $display("FAIL sra4_latency got=%0d exp=5", lat); end
      consume();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL sra4_idle_after got in_ready=%b busy=%b exp 1/0", in_ready, busy); end
   endtask

   task automatic test_logical();
      logic [31:0] zz; int lat;
      req(32'h8000_0000, 4, 1'b0, 1'b0, 1'b0, zz, lat);
      checks++; if (zz !== 32'h0800_0000) begin failures++; $display("FAIL srl4_z got=%h exp=08000000", zz); end
      checks++; if (lat !== 5) begin failures++; $display("FAIL srl4_latency got=%0d exp=5", lat); end
      consume();
      req(32'h0000_0001, 31, 1'b1, 1'b1, 1'b0, zz, lat);
      checks++; if (zz !== 32'h8000_0000) begin failures++; $display("FAIL sll31_z got=%h exp=80000000", zz); end
      checks++; if (lat !== 32) begin failures++; $display("FAIL sll31_latency got=%0d exp=32", lat); end
      consume();
   endtask

   task automatic test_zero_hold();
      logic [31:0] zz; int lat;
      req(32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, zz, lat);
      checks++; if (zz !== 32'h1234_5678) begin failures++; $display("FAIL sh0_z got=%h exp=12345678", zz); end
      checks++; if (lat !== 1) begin failures++; $display("FAIL sh0_latency got=%0d exp=1", lat); end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; x = 32'hDEAD_BEEF; shamt = 5'd3;
         @(negedge clk);
         checks++; if (z !== 32'h1234_5678) begin failures++; $display("FAIL hold_z[%0d] got=%h exp=12345678", i, z); end
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
      end
      in_valid = 1'b0;
      consume();
      @(negedge clk);
      checks++; if (z !== 32'h1234_5678 || out_valid !== 1'b0) begin failures++; $display("FAIL idle_hold got z=%h ov=%b exp 12345678/0", z, out_valid); end
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      x = 32'hFFFF_0000; shamt = 5'd10; dir = 1'b0; arith = 1'b0; rot = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++; if (z !== 32'h1234_5678) begin failures++; $display("FAIL shift_z_hold got=%h exp=12345678", z); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL shift_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL shift_busy got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
      checks++; if (z !== 32'h0) begin failures++; $display("FAIL abort_z got=%h exp=00000000", z); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      @(negedge clk);
      x = 32'h0000_00A5; shamt = 5'd1; dir = 1'b1; arith = 1'b0; in_valid = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL post_reset_accept got busy=%b in_ready=%b exp 1/0", busy, in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_reset_valid got=%b exp=1", out_valid); end
      checks++; if (z !== 32'h0000_014A) begin failures++; $display("FAIL post_reset_z got=%h exp=0000014a", z); end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      logic [31:0] exp_q [$];
      logic [31:0] expv;
      int idx, last_hs, nhs;
      logic acc, hs;
      vals[0] = 32'h0000_0003; vals[1] = 32'h8000_0001; vals[2] = 32'h0F0F_0F0F;
      idx = 0; last_hs = -1; nhs = 0;
      shamt = 5'd2; dir = 1'b1; arith = 1'b0; rot = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 40 && nhs < 3; k++) begin
         @(negedge clk);
         if (idx < 3) begin
            x = vals[idx];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         acc = in_valid & in_ready;
         hs  = out_valid & out_ready;
         if (hs) begin
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            checks++; if (z !== expv) begin failures++; $display("FAIL b2b_z[%0d] got=%h exp=%h", nhs, z, expv); end
            nhs++;
            last_hs = k;
         end
         if (acc) begin
            if (idx > 0) begin
               checks++; if (k !== last_hs + 1) begin failures++; $display("FAIL b2b_gap[%0d] accept_cycle=%0d exp=%0d", idx, k, last_hs + 1); end
            end
            exp_q.push_back(vals[idx] << 2);
            idx++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++; if (nhs !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nhs); end
   endtask

`ifdef SEQ_SHIFTER_ROTATE_EN
   task automatic test_rotate();
      logic [31:0] zz; int lat;
      req(32'h0000_0001, 1, 1'b0, 1'b1, 1'b1, zz, lat);
      checks++; if (zz !== 32'h8000_0000) begin failures++; $display("FAIL ror1_z got=%h exp=80000000", zz); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL ror1_latency got=%0d exp=2", lat); end
      consume();
      req(32'h8000_0001, 4, 1'b1, 1'b0, 1'b1, zz, lat);
      checks++; if (zz !== 32'h0000_0018) begin failures++; $display("FAIL rol4_z got=%h exp=00000018", zz); end
      checks++; if (lat !== 5) begin failures++; $display("FAIL rol4_latency got=%0d exp=5", lat); end
      consume();
   endtask
`endif

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      x = '0; shamt = '0; dir = 1'b0; arith = 1'b0; rot = 1'b0;
      test_reset();
      test_arith_right();
      test_logical();
      test_zero_hold();
      test_reset_abort();
`ifdef SEQ_SHIFTER_ROTATE_EN
      test_rotate();
`endif
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
